// File: rtl/fetch_unit_pkg.sv
// Shared widths, BHT counter encodings and fetch-queue payload for the fetch stage.
package fetch_unit_pkg;

  localparam int unsigned PC_W     = 4;
  localparam int unsigned INST_W   = 16;
  localparam int unsigned FQ_DEPTH = 4;
  localparam int unsigned BHT_LOG  = 3;
  localparam int unsigned BHT_N    = 1 << BHT_LOG;
  localparam int unsigned FQ_PTR_W = $clog2(FQ_DEPTH);
  localparam int unsigned FQ_CNT_W = FQ_PTR_W + 1;

  // Conditional branch: opcode in the top nibble, PC-relative offset in the low bits.
  localparam logic [3:0] OPC_BR = 4'hC;

  typedef enum logic [1:0] {
    BHT_SNT = 2'b00,
    BHT_WNT = 2'b01,
    BHT_WT  = 2'b10,
    BHT_ST  = 2'b11
  } bht_ctr_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
    logic              pred;
  } fq_entry_t;

endpackage

// File: rtl/fetch_unit_bht.sv
// Branch history table: 2-bit saturating counters, one read port, one update port.
module fetch_unit_bht
  import fetch_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [BHT_LOG-1:0] rd_idx_i,
  output logic               rd_taken_c_o,
  input  logic               upd_valid_i,
  input  logic [BHT_LOG-1:0] upd_idx_i,
  input  logic               upd_taken_i
);

  bht_ctr_e ctr_q [BHT_N];
  bht_ctr_e upd_ctr_d;

  // Prediction reads the registered counter, so a same-cycle update is not seen.
  assign rd_taken_c_o = (ctr_q[rd_idx_i] == BHT_WT) || (ctr_q[rd_idx_i] == BHT_ST);

  // Saturating step of the addressed counter toward the resolved direction.
  always_comb begin
    upd_ctr_d = ctr_q[upd_idx_i];
    case (ctr_q[upd_idx_i])
      BHT_SNT: upd_ctr_d = upd_taken_i ? BHT_WNT : BHT_SNT;
      BHT_WNT: upd_ctr_d = upd_taken_i ? BHT_WT  : BHT_SNT;
      BHT_WT:  upd_ctr_d = upd_taken_i ? BHT_ST  : BHT_WNT;
      BHT_ST:  upd_ctr_d = upd_taken_i ? BHT_ST  : BHT_WT;
      default: upd_ctr_d = BHT_WNT;
    endcase
  end

  // Counter array; reset leaves every entry weakly not-taken.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 0; i < BHT_N; i++) begin
        ctr_q[i] <= BHT_WNT;
      end
    end else if (upd_valid_i) begin
      ctr_q[upd_idx_i] <= upd_ctr_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: PC, branch predecode/prediction and a small FIFO toward rename.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [INST_W-1:0]   imem_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_W-1:0]     out_pc,
  output logic [INST_W-1:0]   out_inst,
  output logic                out_pred_taken,
  input  logic                redirect_valid,
  input  logic [PC_W-1:0]     redirect_pc,
  input  logic                upd_valid,
  input  logic [PC_W-1:0]     upd_pc,
  input  logic                upd_taken,
  output logic [FQ_CNT_W-1:0] fq_count
);

  localparam logic [FQ_CNT_W-1:0] FQ_FULL = FQ_CNT_W'(FQ_DEPTH);

  logic [PC_W-1:0]     pc_q, pc_d;
  logic [FQ_PTR_W-1:0] head_q, head_d;
  logic [FQ_PTR_W-1:0] tail_q, tail_d;
  logic [FQ_CNT_W-1:0] count_q, count_d;
  fq_entry_t           fq_q [FQ_DEPTH];
  fq_entry_t           head_ent;

  logic            is_br_c;
  logic [PC_W-1:0] br_off_c;
  logic            bht_taken_c;
  logic            pred_c;
  logic            pop_c;
  logic            push_c;
  logic            unused_upd_pc_c;

  // Only the low index bits of the update PC address the table.
  assign unused_upd_pc_c = ^upd_pc[PC_W-1:BHT_LOG];

  fetch_unit_bht u_bht (
    .clk          (clk),
    .rst          (rst),
    .rd_idx_i     (pc_q[BHT_LOG-1:0]),
    .rd_taken_c_o (bht_taken_c),
    .upd_valid_i  (upd_valid),
    .upd_idx_i    (upd_pc[BHT_LOG-1:0]),
    .upd_taken_i  (upd_taken)
  );

  // Predecode and direction prediction on the word currently being fetched.
  assign is_br_c  = (imem_data[INST_W-1 -: 4] == OPC_BR);
  assign br_off_c = imem_data[PC_W-1:0];
  assign pred_c   = is_br_c && bht_taken_c;

  assign pop_c  = out_valid && out_ready;
  assign push_c = !redirect_valid && ((count_q < FQ_FULL) || pop_c);

  // Next PC and queue pointers; a redirect flushes and overrides push/pop.
  always_comb begin
    pc_d    = pc_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_c) begin
        tail_d = tail_q + FQ_PTR_W'(1);
        pc_d   = pred_c ? (pc_q + br_off_c) : (pc_q + PC_W'(1));
      end
      if (pop_c) begin
        head_d = head_q + FQ_PTR_W'(1);
      end
      if (push_c && !pop_c) begin
        count_d = count_q + FQ_CNT_W'(1);
      end else if (pop_c && !push_c) begin
        count_d = count_q - FQ_CNT_W'(1);
      end
    end
  end

  // PC and queue control state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      pc_q    <= pc_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Queue storage; contents are only meaningful below count, so no reset.
  always_ff @(posedge clk) begin
    if (rst && push_c) begin
      fq_q[tail_q] <= '{pc: pc_q, inst: imem_data, pred: pred_c};
    end
  end

  assign head_ent       = fq_q[head_q];
  assign imem_addr      = pc_q;
  assign out_valid      = (count_q != '0);
  assign out_pc         = head_ent.pc;
  assign out_inst       = head_ent.inst;
  assign out_pred_taken = head_ent.pred;
  assign fq_count       = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: queue/array reference model, directed scenarios and random traffic.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [3:0]  imem_addr;
  logic [15:0] imem_data;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_pc;
  logic [15:0] out_inst;
  logic        out_pred_taken;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;
  logic        upd_valid;
  logic [3:0]  upd_pc;
  logic        upd_taken;
  logic [2:0]  fq_count;

  logic [15:0] imem [16];

  fetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst),
    .out_pred_taken (out_pred_taken),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .fq_count       (fq_count)
  );

  assign imem_data = imem[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the queue is a plain SV queue, counters are small integers.
  typedef struct {
    logic [3:0]  pc;
    logic [15:0] inst;
    logic        pred;
  } ent_t;

  ent_t       mq[$];
  logic [3:0] m_pc;
  int         m_bht [8];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  task automatic model_step();
    logic [15:0] w;
    logic        pred;
    bit          pop;
    bit          push;
    if (!rst) begin
      mq.delete();
      m_pc = 4'd0;
      for (int i = 0; i < 8; i++) m_bht[i] = 1;
      return;
    end
    w    = imem[m_pc];
    pred = (w[15:12] == 4'hC) && (m_bht[m_pc[2:0]] >= 2);
    if (redirect_valid) begin
      mq.delete();
      m_pc = redirect_pc;
    end else begin
      pop  = (mq.size() > 0) && out_ready;
      push = (mq.size() < 4) || pop;
      if (pop) void'(mq.pop_front());
      if (push) begin
        mq.push_back('{pc: m_pc, inst: w, pred: pred});
        m_pc = pred ? 4'(m_pc + w[3:0]) : 4'(m_pc + 4'd1);
      end
    end
    if (upd_valid) begin
      if (upd_taken) begin
        if (m_bht[upd_pc[2:0]] < 3) m_bht[upd_pc[2:0]]++;
      end else begin
        if (m_bht[upd_pc[2:0]] > 0) m_bht[upd_pc[2:0]]--;
      end
    end
  endtask

  task automatic compare_all();
    chk("fq_count", 32'(fq_count), 32'(mq.size()));
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("imem_addr", 32'(imem_addr), 32'(m_pc));
    if (mq.size() > 0) begin
      chk("out_pc", 32'(out_pc), 32'(mq[0].pc));
      chk("out_inst", 32'(out_inst), 32'(mq[0].inst));
      chk("out_pred_taken", 32'(out_pred_taken), 32'(mq[0].pred));
    end
  endtask

  // Inputs change at the falling edge; the model advances with the rising edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle_inputs();
    redirect_valid = 1'b0;
    redirect_pc    = 4'd0;
    upd_valid      = 1'b0;
    upd_pc         = 4'd0;
    upd_taken      = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  initial begin
    logic [15:0] w;
    for (int i = 0; i < 16; i++) imem[i] = 16'h1000 + 16'(i);
    rst       = 1'b0;
    out_ready = 1'b1;
    idle_inputs();
    for (int i = 0; i < 8; i++) m_bht[i] = 1;
    m_pc = 4'd0;
    @(negedge clk);

    // Reset state.
    do_reset();
    chk("rst_count", 32'(fq_count), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(imem_addr), 32'd0);

    // Straight-line stream with the consumer always ready.
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("line_pc", 32'(out_pc), 32'(k));
      chk("line_pred", 32'(out_pred_taken), 32'd0);
      chk("line_count", 32'(fq_count), 32'd1);
    end

    // Back-pressure fills the queue and stalls the PC; release drains in order.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    chk("full_count", 32'(fq_count), 32'd4);
    chk("full_addr", 32'(imem_addr), 32'd4);
    chk("full_head", 32'(out_pc), 32'd0);
    out_ready = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk("drain_pc", 32'(out_pc), 32'(k));
      chk("drain_count", 32'(fq_count), 32'd4);
    end

    // Training the counter at index 2 to taken redirects fetch to 2+5.
    imem[2] = 16'hC005;
    do_reset();
    out_ready = 1'b1;
    upd_valid = 1'b1; upd_pc = 4'd2; upd_taken = 1'b1;
    tick();
    tick();
    idle_inputs();
    tick();
    chk("br_pc", 32'(out_pc), 32'd2);
    chk("br_pred", 32'(out_pred_taken), 32'd1);
    tick();
    chk("br_target", 32'(out_pc), 32'd7);
    upd_valid = 1'b1; upd_pc = 4'd2; upd_taken = 1'b0;
    tick();
    tick();
    idle_inputs();
    redirect_valid = 1'b1; redirect_pc = 4'd2;
    tick();
    idle_inputs();
    tick();
    chk("br_nt_pc", 32'(out_pc), 32'd2);
    chk("br_nt_pred", 32'(out_pred_taken), 32'd0);
    tick();
    chk("br_nt_next", 32'(out_pc), 32'd3);

    // Redirect with three entries queued and a simultaneous pop.
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("pre_redir_count", 32'(fq_count), 32'd3);
    out_ready = 1'b1;
    redirect_valid = 1'b1; redirect_pc = 4'd9;
    tick();
    idle_inputs();
    chk("redir_count", 32'(fq_count), 32'd0);
    chk("redir_valid", 32'(out_valid), 32'd0);
    tick();
    chk("redir_valid2", 32'(out_valid), 32'd1);
    chk("redir_pc", 32'(out_pc), 32'd9);

    // Reset mid-stream with trained counters and a half-full queue.
    imem[0] = 16'hC003;
    do_reset();
    out_ready = 1'b0;
    upd_valid = 1'b1; upd_pc = 4'd0; upd_taken = 1'b1;
    tick();
    tick();
    idle_inputs();
    chk("mid_count", 32'(fq_count), 32'd2);
    do_reset();
    chk("mid_rst_count", 32'(fq_count), 32'd0);
    chk("mid_rst_addr", 32'(imem_addr), 32'd0);
    tick();
    chk("mid_rst_pred", 32'(out_pred_taken), 32'd0);
    chk("mid_rst_next", 32'(imem_addr), 32'd1);

    // Random traffic against the model.
    for (int i = 0; i < 16; i++) begin
      w = 16'($urandom());
      if ($urandom_range(0, 2) == 0) w[15:12] = 4'hC;
      else if (w[15:12] == 4'hC) w[15:12] = 4'h3;
      imem[i] = w;
    end
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst            = ($urandom_range(0, 99) != 0);
      out_ready      = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 99) < 6);
      redirect_pc    = 4'($urandom());
      upd_valid      = ($urandom_range(0, 9) < 3);
      upd_pc         = 4'($urandom());
      upd_taken      = 1'($urandom());
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
